// File: rtl/simd_product_accumulator.sv
// Purpose: accumulates bursts of 9x9 SIMD multiplier products, full (one 18-bit) or packed (two carry-isolated lanes).
// Latency: result is presented one cycle after the last accepted product; one product per cycle while accumulating.
// Backpressure: in_ready only while a burst is open; the result is held with out_valid until out_ready.
module simd_product_accumulator #(
    parameter int P_W   = 18,
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_half_mode,
    input  logic             i_p_sign,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [P_W-1:0]   i_p,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [ACC_W-1:0] o_acc,
    output logic [1:0]       o_ovf
);

    // Packed mode: lane0 takes product bits [7:0], lane1 takes the remaining upper bits.
    localparam int HW   = ACC_W / 2;
    localparam int L0_W = 8;
    localparam int L1_W = P_W - L0_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [1:0]       r_ovf;
    logic             r_out_valid;
    logic             r_in_ready;
    logic [LEN_W-1:0] r_count;
    logic             r_half;
    logic             r_sign;

    logic [ACC_W-1:0] w_ext_full;
    logic [ACC_W:0]   w_sum_full;
    logic [HW-1:0]    w_ext_l0;
    logic [HW-1:0]    w_ext_l1;
    logic [HW:0]      w_sum_l0;
    logic [HW:0]      w_sum_l1;
    logic [ACC_W-1:0] w_acc_next;
    logic [1:0]       w_ovf_step;
    logic             w_start_ok;
    logic             w_beat;

    // A start is taken from IDLE, or from DONE in the same cycle the result is handed off.
    assign w_start_ok = i_start && ((r_state == S_IDLE) ||
                                    ((r_state == S_DONE) && i_out_ready));
    assign w_beat     = (r_state == S_ACCUM) && r_in_ready && i_in_valid;

    // Extend the product (whole or per lane) using the latched sign mode, then add with carry visibility.
    always_comb begin
        w_ext_full = r_sign ? {{(ACC_W-P_W){i_p[P_W-1]}}, i_p} : {{(ACC_W-P_W){1'b0}}, i_p};
        w_ext_l0   = r_sign ? {{(HW-L0_W){i_p[L0_W-1]}}, i_p[L0_W-1:0]}
                            : {{(HW-L0_W){1'b0}}, i_p[L0_W-1:0]};
        w_ext_l1   = r_sign ? {{(HW-L1_W){i_p[P_W-1]}}, i_p[P_W-1:L0_W]}
                            : {{(HW-L1_W){1'b0}}, i_p[P_W-1:L0_W]};

        w_sum_full = {1'b0, r_acc} + {1'b0, w_ext_full};
        w_sum_l0   = {1'b0, r_acc[HW-1:0]} + {1'b0, w_ext_l0};
        w_sum_l1   = {1'b0, r_acc[ACC_W-1:HW]} + {1'b0, w_ext_l1};

        w_ovf_step = 2'b00;
        if (r_half) begin
            // Lanes are summed separately so no carry crosses the lane boundary.
            w_acc_next = {w_sum_l1[HW-1:0], w_sum_l0[HW-1:0]};
            if (r_sign) begin
                w_ovf_step[0] = (r_acc[HW-1] == w_ext_l0[HW-1]) &&
                                (w_sum_l0[HW-1] != r_acc[HW-1]);
                w_ovf_step[1] = (r_acc[ACC_W-1] == w_ext_l1[HW-1]) &&
                                (w_sum_l1[HW-1] != r_acc[ACC_W-1]);
            end else begin
                w_ovf_step[0] = w_sum_l0[HW];
                w_ovf_step[1] = w_sum_l1[HW];
            end
        end else begin
            w_acc_next = w_sum_full[ACC_W-1:0];
            if (r_sign) begin
                w_ovf_step[0] = (r_acc[ACC_W-1] == w_ext_full[ACC_W-1]) &&
                                (w_sum_full[ACC_W-1] != r_acc[ACC_W-1]);
            end else begin
                w_ovf_step[0] = w_sum_full[ACC_W];
            end
        end
    end

    // Burst FSM: latch burst parameters on start, accumulate beats, hold result until handed off.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_ovf       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_count     <= '0;
            r_half      <= 1'b0;
            r_sign      <= 1'b0;
        end else if (w_start_ok) begin
            r_count <= i_len;
            r_half  <= i_half_mode;
            r_sign  <= i_p_sign;
            r_acc   <= '0;
            r_ovf   <= '0;
            if (i_len != '0) begin
                r_state     <= S_ACCUM;
                r_in_ready  <= 1'b1;
                r_out_valid <= 1'b0;
            end else begin
                r_state     <= S_DONE;
                r_in_ready  <= 1'b0;
                r_out_valid <= 1'b1;
            end
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (w_beat) begin
                        r_acc   <= w_acc_next;
                        r_ovf   <= r_ovf | w_ovf_step;
                        r_count <= r_count - LEN_W'(1);
                        if (r_count == LEN_W'(1)) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                S_IDLE: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_acc       = r_acc;
    assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_simd_product_accumulator.sv
// Bench for simd_product_accumulator: directed bursts, scoreboard of expected results
// built from an integer reference model, checked when the result is handed off.
module tb_simd_product_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic        half_mode;
    logic        p_sign;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] p;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] acc;
    logic [1:0]  ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int stalls  = 0;

    logic [25:0] exp_q[$];
    logic [23:0] m_acc;
    logic [1:0]  m_ovf;
    int          m_len;
    int          m_cnt;
    bit          m_half;
    bit          m_sign;
    logic [23:0] last_acc;
    logic [1:0]  last_ovf;

    simd_product_accumulator #(.P_W(18), .ACC_W(24), .LEN_W(8)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_len       (len),
        .i_half_mode (half_mode),
        .i_p_sign    (p_sign),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_p         (p),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_acc       (acc),
        .o_ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference add of one lane using plain integer arithmetic and range tests.
    task automatic add_lane(input longint a_raw, input longint b_raw, input int aw, input int bw,
                            input bit sgn, output longint res, output bit ov);
        longint a, b, s;
        a = a_raw;
        b = b_raw;
        if (sgn) begin
            if (a >= (longint'(1) << (aw-1))) a = a - (longint'(1) << aw);
            if (b >= (longint'(1) << (bw-1))) b = b - (longint'(1) << bw);
            s  = a + b;
            ov = (s < -(longint'(1) << (aw-1))) || (s > (longint'(1) << (aw-1)) - 1);
        end else begin
            s  = a + b;
            ov = (s >= (longint'(1) << aw));
        end
        res = s & ((longint'(1) << aw) - 1);
    endtask

    task automatic model_start(input int l, input bit h, input bit s);
        m_acc  = '0;
        m_ovf  = '0;
        m_len  = l;
        m_cnt  = 0;
        m_half = h;
        m_sign = s;
        if (l == 0) exp_q.push_back({m_ovf, m_acc});
    endtask

    task automatic model_add(input logic [17:0] pv);
        longint r0, r1;
        bit o0, o1;
        if (m_half) begin
            add_lane(longint'(m_acc[11:0]), longint'(pv[7:0]), 12, 8, m_sign, r0, o0);
            add_lane(longint'(m_acc[23:12]), longint'(pv[17:8]), 12, 10, m_sign, r1, o1);
            m_acc = {r1[11:0], r0[11:0]};
            m_ovf = m_ovf | {o1, o0};
        end else begin
            add_lane(longint'(m_acc), longint'(pv), 24, 18, m_sign, r0, o0);
            m_acc    = r0[23:0];
            m_ovf[0] = m_ovf[0] | o0;
        end
        m_cnt++;
        if (m_cnt == m_len) exp_q.push_back({m_ovf, m_acc});
    endtask

    task automatic do_start(input logic [7:0] l, input bit h, input bit s);
        start     = 1'b1;
        len       = l;
        half_mode = h;
        p_sign    = s;
        model_start(int'(l), h, s);
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [17:0] pv);
        int w;
        in_valid = 1'b1;
        p        = pv;
        w        = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
            stalls++;
        end
        check("beat_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        model_add(pv);
        if (m_cnt == m_len) check("latency_out_valid", 32'(out_valid), 32'd1);
    endtask

    // Wait for a result, optionally stall it, then take it (optionally starting a new burst in the same cycle).
    task automatic collect(input int hold, input bit b2b, input logic [7:0] nl, input bit nh, input bit ns);
        int w;
        logic [25:0] e;
        w = 0;
        while (!out_valid && w < 20) begin
            tick();
            w++;
        end
        check("result_out_valid", 32'(out_valid), 32'd1);
        check("scoreboard_nonempty", 32'(exp_q.size() > 0), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 26'h0;
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            check("hold_acc", 32'(acc), 32'(e[23:0]));
            tick();
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        last_acc  = acc;
        last_ovf  = ovf;
        check("result_acc", 32'(acc), 32'(e[23:0]));
        check("result_ovf", 32'(ovf), 32'(e[25:24]));
        if (b2b) begin
            start     = 1'b1;
            len       = nl;
            half_mode = nh;
            p_sign    = ns;
            model_start(int'(nl), nh, ns);
        end
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("after_handoff_out_valid", 32'(out_valid), 32'(b2b && nl == 0));
        if (b2b) check("b2b_in_ready", 32'(in_ready), 32'(nl != 0));
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        len       = '0;
        half_mode = 1'b0;
        p_sign    = 1'b0;
        in_valid  = 1'b0;
        p         = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;
        tick();

        // Product offered in IDLE must not be taken.
        in_valid = 1'b1;
        p        = 18'h00055;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;

        // Full signed -1 x3; a mid-burst start with other parameters is ignored.
        do_start(8'd3, 1'b0, 1'b1);
        send_beat(18'h3FFFF);
        start = 1'b1; len = 8'd7; half_mode = 1'b1; p_sign = 1'b0;
        send_beat(18'h3FFFF);
        start = 1'b0; half_mode = 1'b0;
        send_beat(18'h3FFFF);
        collect(0, 1'b0, 8'd0, 1'b0, 1'b0);
        check("full_signed_acc", 32'(last_acc), 32'h00FFFFFD);
        check("full_signed_ovf", 32'(last_ovf), 32'd0);

        // Packed signed: lane0 goes negative without disturbing lane1.
        do_start(8'd2, 1'b1, 1'b1);
        send_beat({10'h005, 8'hF0});
        send_beat({10'h005, 8'hF0});
        collect(0, 1'b0, 8'd0, 1'b0, 1'b0);
        check("packed_signed_acc", 32'(last_acc), 32'h0000AFE0);
        check("packed_signed_ovf", 32'(last_ovf), 32'd0);

        // Packed unsigned: lane0 wraps, carry must not reach lane1.
        do_start(8'd17, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) send_beat(18'h000FF);
        collect(0, 1'b0, 8'd0, 1'b0, 1'b0);
        check("packed_wrap_acc", 32'(last_acc), 32'h000000EF);
        check("packed_wrap_ovf", 32'(last_ovf), 32'd1);

        // Packed signed random burst.
        do_start(8'd6, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) send_beat(18'($urandom));
        collect(0, 1'b0, 8'd0, 1'b0, 1'b0);

        // Unsigned overflow over a long burst at full rate.
        stalls = 0;
        do_start(8'd65, 1'b0, 1'b0);
        for (int i = 0; i < 65; i++) send_beat(18'h3FFFF);
        check("no_bubbles", 32'(stalls), 32'd0);
        collect(0, 1'b0, 8'd0, 1'b0, 1'b0);
        check("unsigned_ovf_acc", 32'(last_acc), 32'h0003FFBF);
        check("unsigned_ovf_ovf", 32'(last_ovf), 32'd1);

        // Full signed positive overflow.
        do_start(8'd70, 1'b0, 1'b1);
        for (int i = 0; i < 70; i++) send_beat(18'h1FFFF);
        collect(0, 1'b0, 8'd0, 1'b0, 1'b0);
        check("signed_ovf_flag", 32'(last_ovf), 32'd1);

        // Gapped input and a stalled result.
        do_start(8'd4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_beat(18'($urandom));
            if (i < 3) tick();
        end
        collect(5, 1'b0, 8'd0, 1'b0, 1'b0);

        // Zero-length burst, then back-to-back start into a packed burst.
        do_start(8'd0, 1'b0, 1'b0);
        check("len0_out_valid", 32'(out_valid), 32'd1);
        check("len0_acc", 32'(acc), 32'd0);
        collect(0, 1'b1, 8'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_beat(18'($urandom));
        collect(0, 1'b0, 8'd0, 1'b0, 1'b0);

        // Reset after two of five beats discards the partial burst.
        do_start(8'd5, 1'b0, 1'b1);
        send_beat(18'h00123);
        send_beat(18'h00456);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_acc", 32'(acc), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        tick();
        check("midrst_idle_out_valid", 32'(out_valid), 32'd0);

        // Normal operation resumes after reset.
        do_start(8'd1, 1'b0, 1'b1);
        send_beat(18'h2ABCD);
        collect(0, 1'b0, 8'd0, 1'b0, 1'b0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
